// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
package mult_arb_pkg;
    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;
    localparam int ID_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        RESP
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts just past ptr and takes the first set request.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Offset 1 is the highest priority, offset NUM_REQ wraps back to the last winner.
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_any && req[j] && (j == ((int'(ptr) + i) % NUM_REQ))) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = ID_W'(j);
                    gnt_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multi-cycle multiplier between NUM_REQ clients: round-robin grant,
// one-cycle start, busy tracking with a rise timeout, tagged result return.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    output logic [ID_W-1:0]                resp_id,
    output logic [PRODUCT_W-1:0]           resp_product,
    output logic                           resp_err,
    output logic                           mult_start,
    input  logic                           mult_busy,
    output logic [OPERAND_W-1:0]           mult_a,
    output logic [OPERAND_W-1:0]           mult_b,
    input  logic [PRODUCT_W-1:0]           mult_product,
    output logic [15:0]                    op_count
);

    localparam int                TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic [OPERAND_W-1:0]   a_q, a_d;
    logic [OPERAND_W-1:0]   b_q, b_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic [PRODUCT_W-1:0]   product_q, product_d;
    logic [15:0]            op_count_q, op_count_d;

    logic [NUM_REQ-1:0]     gnt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        resp_id_d  = resp_id_q;
        a_d        = a_q;
        b_d        = b_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        product_d  = product_q;
        op_count_d = op_count_q;
        req_ready  = '0;
        mult_start = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (gnt_any) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (gnt[j]) begin
                            a_d = req_a[j*OPERAND_W +: OPERAND_W];
                            b_d = req_b[j*OPERAND_W +: OPERAND_W];
                        end
                    end
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                mult_start = 1'b1;
                tmo_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mult_busy) begin
                    state_d = RUN;
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    resp_id_d = id_q;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RUN: begin
                // First idle cycle after busy: the multiplier's product register is final.
                if (!mult_busy) begin
                    product_d = mult_product;
                    resp_id_d = id_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q) begin
                    op_count_d = op_count_q + 16'd1;
                end
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RST;
            id_q       <= '0;
            resp_id_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            product_q  <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            resp_id_q  <= resp_id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            product_q  <= product_d;
            op_count_q <= op_count_d;
        end
    end

    assign mult_a       = a_q;
    assign mult_b       = b_q;
    assign resp_id      = resp_id_q;
    assign resp_product = product_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural 8-busy-cycle multiplier that can be made dead.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [63:0] resp_product;
    logic        resp_err;
    logic        mult_start;
    logic        mult_busy;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [63:0] mult_product;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .NUM_REQ      (2),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .resp_err     (resp_err),
        .mult_start   (mult_start),
        .mult_busy    (mult_busy),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .op_count     (op_count)
    );

    // Multiplier model: busy for 8 cycles after start, product is junk until busy falls.
    logic       stub_dead;
    logic [3:0] m_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_busy    <= 1'b0;
            m_cnt        <= 4'd0;
            mult_product <= 64'd0;
        end else if (mult_busy) begin
            if (m_cnt == 4'd1) begin
                mult_busy    <= 1'b0;
                mult_product <= {32'd0, mult_a} * {32'd0, mult_b};
            end
            m_cnt <= m_cnt - 4'd1;
        end else if (mult_start && !stub_dead) begin
            mult_busy    <= 1'b1;
            m_cnt        <= 4'd8;
            mult_product <= 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Steps until resp_valid is seen; n = steps taken, -1 if none within the budget.
    task automatic wait_resp(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (resp_valid === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    int          n;
    logic        ready_seen;
    int          resp_cyc;
    logic [63:0] prod11;
    logic [1:0]  id11;

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = 64'd0;
        req_b     = 64'd0;
        stub_dead = 1'b0;
        step();
        step();
        chk("rst_ready",   64'(req_ready),    64'h0);
        chk("rst_valid",   64'(resp_valid),   64'h0);
        chk("rst_start",   64'(mult_start),   64'h0);
        chk("rst_mult_a",  64'(mult_a),       64'h0);
        chk("rst_product", resp_product,      64'h0);
        chk("rst_opcount", 64'(op_count),     64'h0);
        reset = 1'b0;

        // 1: single request 3*5
        step();
        req_valid = 2'b01; req_a = 64'h0000_0000_0000_0003; req_b = 64'h0000_0000_0000_0005;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        chk("t1_start",  64'(mult_start), 64'h1);
        chk("t1_mult_a", 64'(mult_a),     64'h3);
        chk("t1_mult_b", 64'(mult_b),     64'h5);
        wait_resp(n);
        chk("t1_latency", 64'(n), 64'd10);
        chk("t1_product", resp_product, 64'hF);
        chk("t1_id",      64'(resp_id),  64'h0);
        chk("t1_err",     64'(resp_err), 64'h0);
        step();
        chk("t1_opcount", 64'(op_count),   64'h1);
        chk("t1_vld_low", 64'(resp_valid), 64'h0);

        // 2: both requesters, fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 2'b11;
        req_a = {32'h1234_5678, 32'hFFFF_FFFF};
        req_b = {32'h0000_0010, 32'hFFFF_FFFF};
        #1;
        chk("t2_ready0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b10;
        wait_resp(n);
        chk("t2_lat0",  64'(n), 64'd10);
        chk("t2_prod0", resp_product, 64'hFFFF_FFFE_0000_0001);
        chk("t2_id0",   64'(resp_id), 64'h0);
        step();
        #1;
        chk("t2_ready1", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        wait_resp(n);
        chk("t2_lat1",  64'(n), 64'd10);
        chk("t2_prod1", resp_product, 64'h0000_0001_2345_6780);
        chk("t2_id1",   64'(resp_id), 64'h1);
        step();
        chk("t2_opcount", 64'(op_count), 64'h2);

        // 3: three back-to-back rounds, both always valid
        req_valid = 2'b11;
        req_a = {32'h0001_0000, 32'h0000_0007};
        req_b = {32'h0001_0000, 32'h0000_0006};
        #1;
        chk("t3_ready", 64'(req_ready), 64'h1);
        for (int r = 0; r < 3; r++) begin
            wait_resp(n);
            chk($sformatf("t3_gap%0d", r), 64'(n), (r == 0) ? 64'd11 : 64'd12);
            chk($sformatf("t3_id%0d", r), 64'(resp_id), (r == 1) ? 64'h1 : 64'h0);
            chk($sformatf("t3_prod%0d", r), resp_product,
                (r == 1) ? 64'h0000_0001_0000_0000 : 64'h2A);
        end
        req_valid = 2'b00;
        step();
        chk("t3_opcount", 64'(op_count), 64'h5);

        // 4: dead multiplier -> timeout error, then normal service
        stub_dead = 1'b1;
        req_valid = 2'b01; req_a = 64'h9; req_b = 64'h9;
        #1;
        chk("t4_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        chk("t4_start", 64'(mult_start), 64'h1);
        wait_resp(n);
        chk("t4_latency", 64'(n), 64'd5);
        chk("t4_err",     64'(resp_err), 64'h1);
        chk("t4_id",      64'(resp_id),  64'h0);
        chk("t4_product", resp_product,  64'h2A);
        chk("t4_opcount", 64'(op_count), 64'h5);
        step();
        chk("t4_opcount_after", 64'(op_count), 64'h5);
        chk("t4_vld_low",       64'(resp_valid), 64'h0);
        stub_dead = 1'b0;
        req_valid = 2'b10; req_a = {32'h100, 32'h0}; req_b = {32'h100, 32'h0};
        #1;
        chk("t4_ready_next", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        wait_resp(n);
        chk("t4_lat_next",  64'(n), 64'd10);
        chk("t4_prod_next", resp_product, 64'h1_0000);
        chk("t4_err_next",  64'(resp_err), 64'h0);
        step();
        chk("t4_opcount_next", 64'(op_count), 64'h6);

        // 5: reset during RUN
        req_valid = 2'b01; req_a = 64'h5; req_b = 64'h5;
        #1;
        chk("t5_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        repeat (5) step();
        reset = 1'b1;
        #1;
        chk("t5_rst_outs",
            {req_ready, resp_valid, resp_id, resp_err, mult_start, mult_a, 16'd0, op_count} |
            {mult_b, 32'd0}, 64'h0);
        chk("t5_rst_product", resp_product, 64'h0);
        step();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (resp_valid !== 1'b0) n++;
        end
        chk("t5_no_resp", 64'(n), 64'h0);
        req_valid = 2'b10; req_a = {32'h0000_ABCD, 32'h0}; req_b = {32'h2, 32'h0};
        #1;
        chk("t5_ready_new", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        wait_resp(n);
        chk("t5_lat_new",  64'(n), 64'd10);
        chk("t5_prod_new", resp_product, 64'h1_579A);
        chk("t5_id_new",   64'(resp_id), 64'h1);
        step();
        chk("t5_opcount", 64'(op_count), 64'h1);

        // 6: req1 arrives mid-operation, granted only back in IDLE
        req_valid = 2'b01; req_a = {32'h20, 32'h3}; req_b = {32'h30, 32'h3};
        #1;
        chk("t6_ready0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        step(); step(); step();
        req_valid = 2'b10;
        req_a = {32'h20, 32'hFFFF};
        ready_seen = 1'b0; resp_cyc = -1; prod11 = 64'd0; id11 = 2'd0;
        for (int c = 4; c <= 11; c++) begin
            #1;
            if (req_ready !== 2'b00) ready_seen = 1'b1;
            if (resp_valid === 1'b1 && resp_cyc < 0) begin
                resp_cyc = c;
                prod11   = resp_product;
                id11     = resp_id;
            end
            step();
        end
        chk("t6_no_early_ready", 64'(ready_seen), 64'h0);
        chk("t6_resp_cycle",     64'(resp_cyc),   64'd11);
        chk("t6_prod0",          prod11,          64'h9);
        chk("t6_id0",            64'(id11),       64'h0);
        #1;
        chk("t6_ready1", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        chk("t6_mult_a", 64'(mult_a), 64'h20);
        chk("t6_mult_b", 64'(mult_b), 64'h30);
        wait_resp(n);
        chk("t6_lat1",  64'(n), 64'd10);
        chk("t6_prod1", resp_product, 64'h600);
        chk("t6_id1",   64'(resp_id), 64'h1);
        step();
        chk("t6_opcount", 64'(op_count), 64'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
